button_press_classifier: RTL and testbench
==========================================

// Module: button_press_classifier
// PURPOSE
//   Consumes the debounced level from the button debouncer and classifies each
//   user gesture as SHORT, LONG or DOUBLE press.
//   Emits one single-cycle pulse per gesture for the UI/control FSMs. Sits
//   directly downstream of the debouncer, one instance per button.
// PARAMETERS
//   LONG_LIMIT  default 50_000_000  consecutive high samples (incl. first) that make a LONG press; >=2
//   DOUBLE_GAP  default 25_000_000  max consecutive low samples after release still allowing a DOUBLE; >=1
// PORTS
//   i_clk        input   1  system clock
//   i_rst        input   1  reset
//   i_debounced  input   1  debounced button level, 1 = pressed
//   o_short      output  1  1-cycle pulse: single short press completed
//   o_long       output  1  1-cycle pulse: press held LONG_LIMIT samples
//   o_double     output  1  1-cycle pulse: second press released within gap
//   o_busy       output  1  high whenever FSM is not IDLE
// BEHAVIOUR
// - One clock i_clk; i_rst synchronous, active-high. All outputs registered.
//   During reset and the cycle after it, all outputs are 0.
// - Edge register prev samples i_debounced each edge. Reset value of prev is 1.
//   rise = i_debounced & ~prev. A button held through reset is ignored until
//   it is released.
// - Counter width = $clog2(max(LONG_LIMIT,DOUBLE_GAP)+1). Counter saturates
//   and never wraps.
// - States:
//   IDLE: rise -> PRESSED, cnt=1.
//   PRESSED: input high -> cnt++. On the edge where the high-sample count
//     reaches LONG_LIMIT: o_long=1 for that cycle, -> LONG_HELD.
//     Input low (release) -> WAIT_GAP, cnt=1 (first low sample counts).
//   LONG_HELD: no events; input low -> IDLE. No SHORT is issued on this release.
//   WAIT_GAP: input low -> cnt++. On the edge where the low-sample count
//     reaches DOUBLE_GAP: o_short=1, -> IDLE.
//     Input high before that edge -> SECOND.
//   SECOND: input low -> o_double=1 on that edge, -> IDLE. Second-press
//     duration is not timed; no LONG is issued from SECOND.
// - Boundaries:
//   Release on the same edge the count would reach LONG_LIMIT: release wins,
//     because LONG requires a high sample.
//   Press on the sample after the DOUBLE_GAP-th low sample: SHORT was already
//     issued and the press starts a new gesture from IDLE.
//   At most one of o_short/o_long/o_double is high in any cycle. Exactly one
//     event is issued per gesture.
//   o_busy = (state != IDLE), registered with state.
// - Reset mid-operation: state -> IDLE, cnt=0, prev=1. Any pending gesture is
//   discarded and no pulse is emitted for it.
// TESTING  (bench params LONG_LIMIT=20, DOUBLE_GAP=10, 10 ns clock)
// 1. High 5 cycles, then low 30 -> o_short exactly once, on the 10th low
//    sample; o_long/o_double never high; o_busy low afterwards.
// 2. High 30 cycles, then low -> o_long exactly once, on the 20th high sample;
//    no o_short on release; o_busy drops 1 cycle after release.
// 3. High 5, low 4, high 5, low 20 -> o_double exactly once, on the second
//    release edge; no o_short, no o_long.
// 4. Gap boundary: high 5, low 9, high 3 -> o_double.
//    Repeat with low 10 -> o_short at the 10th low sample, then the later
//    press yields its own o_short.
// 5. i_debounced high throughout reset, held 40 cycles, released, idle 30 ->
//    no pulses at all.
// 6. Reset pulse during WAIT_GAP (after 3 low samples) -> no o_short;
//    o_busy=0 after reset; a new short press then yields one o_short.
//    Every test also checks total pulse counts per output.

Source files
------------

// File: rtl/button_press_classifier.sv
// Purpose : classify each debounced button gesture as SHORT, LONG or DOUBLE press.
// Latency : one pulse per gesture, registered on the clock edge that samples the deciding level.
// Backpr. : none; event pulses are single-cycle and fire-and-forget.
//
// Ports
//   i_clk        system clock
//   i_rst        synchronous active-high reset
//   i_debounced  debounced button level, 1 = pressed
//   o_short      1-cycle pulse: single short press completed (gap expired)
//   o_long       1-cycle pulse: press held LONG_LIMIT samples
//   o_double     1-cycle pulse: second press released within the gap
//   o_busy       high whenever the classifier is not idle
module button_press_classifier #(
    parameter int unsigned LONG_LIMIT = 50_000_000,
    parameter int unsigned DOUBLE_GAP = 25_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_debounced,
    output logic o_short,
    output logic o_long,
    output logic o_double,
    output logic o_busy
);

    localparam int unsigned MAX_LIMIT = (LONG_LIMIT > DOUBLE_GAP) ? LONG_LIMIT : DOUBLE_GAP;
    localparam int          CNT_W     = $clog2(MAX_LIMIT + 1);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LONG_CNT = CNT_W'(LONG_LIMIT);
    localparam logic [CNT_W-1:0] GAP_CNT  = CNT_W'(DOUBLE_GAP);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_LONG_HELD,
        ST_WAIT_GAP,
        ST_SECOND
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_q, prev_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             double_q, double_d;
    logic             busy_q, busy_d;

    logic             rise;
    logic [CNT_W-1:0] cnt_inc;

    // prev resets to 1 so a button held through reset never looks like a new press.
    assign rise    = i_debounced & ~prev_q;

    // Saturating increment: the counter never wraps back to a small value.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prev_d   = i_debounced;
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_PRESSED;
                    cnt_d   = CNT_ONE;
                end
            end

            ST_PRESSED: begin
                if (i_debounced) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == LONG_CNT) begin
                        long_d  = 1'b1;
                        state_d = ST_LONG_HELD;
                    end
                end else begin
                    // The release sample is already the first low sample of the gap.
                    // A release on the would-be LONG edge lands here: LONG needs a high sample.
                    if (GAP_CNT == CNT_ONE) begin
                        short_d = 1'b1;
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_WAIT_GAP;
                        cnt_d   = CNT_ONE;
                    end
                end
            end

            ST_LONG_HELD: begin
                // LONG already reported; the release is silent.
                if (!i_debounced) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end

            ST_WAIT_GAP: begin
                if (i_debounced) begin
                    state_d = ST_SECOND;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == GAP_CNT) begin
                        short_d = 1'b1;
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
            end

            ST_SECOND: begin
                // Second press is not timed; only its release matters.
                if (!i_debounced) begin
                    double_d = 1'b1;
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            prev_q   <= 1'b1;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prev_q   <= prev_d;
            short_q  <= short_d;
            long_q   <= long_d;
            double_q <= double_d;
            busy_q   <= busy_d;
        end
    end

    assign o_short  = short_q;
    assign o_long   = long_q;
    assign o_double = double_q;
    assign o_busy   = busy_q;

endmodule

// File: tb/tb_button_press_classifier.sv
// Purpose : directed stimulus for button_press_classifier with a queued scoreboard.
// Latency : expected pulses are tagged with the clock edge that samples the deciding level.
// Backpr. : none; the monitor pops one expectation per observed pulse.
module tb_button_press_classifier;

    localparam int LL = 20;
    localparam int DG = 10;

    localparam int K_NONE   = -1;
    localparam int K_SHORT  = 0;
    localparam int K_LONG   = 1;
    localparam int K_DOUBLE = 2;

    logic clk = 1'b0;
    logic rst;
    logic deb;
    logic o_short, o_long, o_double, o_busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int n_short = 0, n_long = 0, n_double = 0;
    int e_short = 0, e_long = 0, e_double = 0;

    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    button_press_classifier #(
        .LONG_LIMIT (LL),
        .DOUBLE_GAP (DG)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_debounced (deb),
        .o_short     (o_short),
        .o_long      (o_long),
        .o_double    (o_double),
        .o_busy      (o_busy)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive level v for n samples; on sample number 'at' (1-based) expect a pulse of 'kind'.
    task automatic phase(input logic v, input int n, input int at, input int kind);
        exp_t e;
        for (int i = 1; i <= n; i++) begin
            deb = v;
            @(posedge clk);
            #1;
            if (i == at) begin
                e.kind = kind;
                e.cyc  = cyc;
                sbq.push_back(e);
                if (kind == K_SHORT)  e_short++;
                if (kind == K_LONG)   e_long++;
                if (kind == K_DOUBLE) e_double++;
            end
        end
    endtask

    task automatic do_reset(input logic v, input int n);
        rst = 1'b1;
        deb = v;
        repeat (n) @(posedge clk);
        #1;
        check("outputs_in_reset", int'({o_short, o_long, o_double, o_busy}), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("outputs_after_reset", int'({o_short, o_long, o_double, o_busy}), 0);
    endtask

    task automatic end_test(input string name);
        phase(1'b0, 3, 0, K_NONE);
        $display("%s: pulses short=%0d long=%0d double=%0d", name, n_short, n_long, n_double);
        check("count_short", n_short, e_short);
        check("count_long", n_long, e_long);
        check("count_double", n_double, e_double);
        check("scoreboard_drained", sbq.size(), 0);
        check("busy_idle", int'(o_busy), 0);
    endtask

    // Monitor: every pulse must match the oldest expectation in kind and cycle.
    always @(negedge clk) begin
        int   k;
        exp_t e;
        if (o_short || o_long || o_double) begin
            k = o_short ? K_SHORT : (o_long ? K_LONG : K_DOUBLE);
            check("onehot", $countones({o_short, o_long, o_double}), 1);
            if (o_short)  n_short++;
            if (o_long)   n_long++;
            if (o_double) n_double++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, expected no pulse", k, cyc);
            end else begin
                e = sbq.pop_front();
                check("pulse_kind", k, e.kind);
                check("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        deb = 1'b0;
        do_reset(1'b0, 3);

        // 1: short press, SHORT on the 10th low sample
        phase(1'b1, 5, 0, K_NONE);
        check("t1_busy_pressed", int'(o_busy), 1);
        phase(1'b0, 30, DG, K_SHORT);
        end_test("t1");

        // 2: long hold, LONG on the 20th high sample, silent release
        phase(1'b1, 30, LL, K_LONG);
        check("t2_busy_held", int'(o_busy), 1);
        phase(1'b0, 1, 0, K_NONE);
        check("t2_busy_after_release", int'(o_busy), 0);
        phase(1'b0, 20, 0, K_NONE);
        end_test("t2");

        // 3: double press, DOUBLE on the second release edge
        phase(1'b1, 5, 0, K_NONE);
        phase(1'b0, 4, 0, K_NONE);
        phase(1'b1, 5, 0, K_NONE);
        check("t3_busy_second", int'(o_busy), 1);
        phase(1'b0, 20, 1, K_DOUBLE);
        end_test("t3");

        // 4a: second press after 9 low samples is still a DOUBLE
        phase(1'b1, 5, 0, K_NONE);
        phase(1'b0, 9, 0, K_NONE);
        phase(1'b1, 3, 0, K_NONE);
        phase(1'b0, 15, 1, K_DOUBLE);
        end_test("t4a");

        // 4b: after 10 low samples SHORT fires, the next press is its own gesture
        phase(1'b1, 5, 0, K_NONE);
        phase(1'b0, 10, DG, K_SHORT);
        phase(1'b1, 3, 0, K_NONE);
        phase(1'b0, 15, DG, K_SHORT);
        end_test("t4b");

        // 5: button held through reset is ignored
        do_reset(1'b1, 3);
        phase(1'b1, 40, 0, K_NONE);
        check("t5_busy_held", int'(o_busy), 0);
        phase(1'b0, 30, 0, K_NONE);
        end_test("t5");

        // 6: reset during the gap discards the gesture
        phase(1'b1, 5, 0, K_NONE);
        phase(1'b0, 3, 0, K_NONE);
        check("t6_busy_gap", int'(o_busy), 1);
        do_reset(1'b0, 2);
        phase(1'b0, 15, 0, K_NONE);
        phase(1'b1, 5, 0, K_NONE);
        phase(1'b0, 15, DG, K_SHORT);
        end_test("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
